// File: rtl/snes_input_arbiter.sv
// snes_input_arbiter
//
// Shares the single SNES encoder input byte between the keyboard, IR and
// button-board decoders. Ownership can only change on a rising edge of the
// console latch, so a frame handed to the console never mixes two sources.
// Source data inside the owning source still passes through every cycle.
//
// Optional feature macro: SNES_ARB_LATCH_SYNC_EN
//   defined   : snes_latch goes through a 2-flop synchronizer (3-edge latency)
//   undefined : snes_latch is assumed synchronous to clock (1-edge latency)
//
// Parameters:
//   HOLD_CYCLES  idle clocks an owner may sit at 8'h00 before losing the grant (>= 1)
//
// Ports:
//   clock         system clock
//   reset         synchronous, active-high reset
//   key_data      keyboard decoder byte, nonzero = active
//   ir_data       IR decoder byte, nonzero = active
//   btn_data      button board byte, nonzero = active
//   dip           mode: 00 auto, 01 force key, 10 force IR, 11 force buttons
//   snes_latch    console latch
//   mux_en        registered byte to the SNES encoder
//   owner         current grant: 00 none, 01 key, 10 IR, 11 buttons
//   switch_pulse  one-cycle strobe when owner changes

module snes_input_arbiter #(
  parameter int unsigned HOLD_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] key_data,
  input  logic [7:0] ir_data,
  input  logic [7:0] btn_data,
  input  logic [1:0] dip,
  input  logic       snes_latch,
  output logic [7:0] mux_en,
  output logic [1:0] owner,
  output logic       switch_pulse
);

  localparam int unsigned CntW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CntW-1:0] HoldMax = CntW'(HOLD_CYCLES);

  // Encoding matches the owner port and the forced-mode dip codes.
  typedef enum logic [1:0] {
    OwnNone = 2'b00,
    OwnKey  = 2'b01,
    OwnIr   = 2'b10,
    OwnBtn  = 2'b11
  } owner_e;

  owner_e          owner_q, owner_d;
  logic [CntW-1:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]      owner_data;
  logic            latch_sync;
  logic            latch_prev_q;
  logic            boundary;

  // ---------------------------------------------------------------------------
  // Latch conditioning and edge detect
  // ---------------------------------------------------------------------------
`ifdef SNES_ARB_LATCH_SYNC_EN
  logic latch_s1_q, latch_s2_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      latch_s1_q <= 1'b0;
      latch_s2_q <= 1'b0;
    end else begin
      latch_s1_q <= snes_latch;
      latch_s2_q <= latch_s1_q;
    end
  end

  assign latch_sync = latch_s2_q;
`else
  assign latch_sync = snes_latch;
`endif

  // prev clears on reset, so a latch already high at reset release is an edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      latch_prev_q <= 1'b0;
    end else begin
      latch_prev_q <= latch_sync;
    end
  end

  assign boundary = latch_sync & ~latch_prev_q;

  // ---------------------------------------------------------------------------
  // Owner data select
  // ---------------------------------------------------------------------------
  always_comb begin
    owner_data = 8'h00;
    unique case (owner_q)
      OwnKey:  owner_data = key_data;
      OwnIr:   owner_data = ir_data;
      OwnBtn:  owner_data = btn_data;
      default: owner_data = 8'h00;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Grant decision and idle counter
  // ---------------------------------------------------------------------------
  always_comb begin
    owner_d = owner_q;
    if (boundary) begin
      if (dip != 2'b00) begin
        owner_d = owner_e'(dip);
      end else if ((owner_q != OwnNone) &&
                   ((owner_data != 8'h00) || (hold_cnt_q < HoldMax))) begin
        owner_d = owner_q;
      end else if (btn_data != 8'h00) begin
        owner_d = OwnBtn;
      end else if (key_data != 8'h00) begin
        owner_d = OwnKey;
      end else if (ir_data != 8'h00) begin
        owner_d = OwnIr;
      end else begin
        owner_d = OwnNone;
      end
    end
  end

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if ((owner_d != owner_q) || (owner_q == OwnNone) || (owner_data != 8'h00)) begin
      hold_cnt_d = '0;
    end else if (hold_cnt_q < HoldMax) begin
      hold_cnt_d = hold_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q      <= OwnNone;
      hold_cnt_q   <= '0;
      mux_en       <= 8'h00;
      switch_pulse <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      hold_cnt_q   <= hold_cnt_d;
      mux_en       <= owner_data;
      switch_pulse <= (owner_d != owner_q);
    end
  end

  assign owner = owner_q;

endmodule

// File: tb/tb_snes_input_arbiter.sv
module tb_snes_input_arbiter;

  localparam int unsigned HOLD = 4;
`ifdef SNES_ARB_LATCH_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] key_data, ir_data, btn_data;
  logic [1:0] dip;
  logic       snes_latch;
  logic [7:0] mux_en;
  logic [1:0] owner;
  logic       switch_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  int pulse_count = 0;

  snes_input_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .clock        (clock),
    .reset        (reset),
    .key_data     (key_data),
    .ir_data      (ir_data),
    .btn_data     (btn_data),
    .dip          (dip),
    .snes_latch   (snes_latch),
    .mux_en       (mux_en),
    .owner        (owner),
    .switch_pulse (switch_pulse)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (switch_pulse === 1'b1) pulse_count++;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Latch high for one clock, then wait until the edge where owner may update.
  task automatic latch_cycle();
    snes_latch = 1'b1;
    tick();
    snes_latch = 1'b0;
    for (int i = 1; i < LAT; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; key_data = 8'h00; ir_data = 8'h00; btn_data = 8'h00;
    dip = 2'b00; snes_latch = 1'b0;

    // Reset state, then a latch with nothing active
    tick(); tick();
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_mux", 32'(mux_en), 32'h0);
    check("rst_pulse", 32'(switch_pulse), 32'h0);
    check("rst_hold", 32'(dut.hold_cnt_q), 32'h0);
    reset = 1'b0;
    latch_cycle();
    tick();
    check("idle_owner", 32'(owner), 32'h0);
    check("idle_mux", 32'(mux_en), 32'h0);
    check("idle_no_pulse", 32'(pulse_count), 32'd0);

    // Key and IR together from NONE: key wins
    key_data = 8'h10; ir_data = 8'h01;
    latch_cycle();
    check("grant_key_owner", 32'(owner), 32'h1);
    check("grant_key_pulse", 32'(switch_pulse), 32'h1);
    check("grant_key_mux_lag", 32'(mux_en), 32'h00);
    tick();
    check("grant_key_mux", 32'(mux_en), 32'h10);
    check("grant_key_pulse_off", 32'(switch_pulse), 32'h0);
    check("grant_key_pulse_cnt", 32'(pulse_count), 32'd1);

    // Key idle but still within hold window at boundary: kept
    key_data = 8'h00; btn_data = 8'h80;
    latch_cycle();
    check("hold_keep_owner", 32'(owner), 32'h1);
    check("hold_keep_pulse", 32'(switch_pulse), 32'h0);
    repeat (6) tick();
    latch_cycle();
    check("hold_expire_owner", 32'(owner), 32'h3);
    check("hold_expire_pulse", 32'(switch_pulse), 32'h1);
    tick();
    check("hold_expire_mux", 32'(mux_en), 32'h80);

    // dip change mid-frame waits for the next latch
    ir_data = 8'h00; dip = 2'b10;
    repeat (3) tick();
    check("dip_mid_owner", 32'(owner), 32'h3);
    check("dip_mid_mux", 32'(mux_en), 32'h80);
    latch_cycle();
    check("force_ir_owner", 32'(owner), 32'h2);
    check("force_ir_pulse", 32'(switch_pulse), 32'h1);
    tick();
    check("force_ir_mux", 32'(mux_en), 32'h00);

    // Reset mid-frame with an active IR owner
    ir_data = 8'h05;
    tick(); tick();
    check("ir_mux", 32'(mux_en), 32'h05);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_owner", 32'(owner), 32'h0);
    check("midrst_mux", 32'(mux_en), 32'h00);
    check("midrst_pulse", 32'(switch_pulse), 32'h0);
    repeat (3) tick();
    check("midrst_wait_owner", 32'(owner), 32'h0);
    latch_cycle();
    check("regrant_owner", 32'(owner), 32'h2);
    check("regrant_pulse", 32'(switch_pulse), 32'h1);
    tick();
    check("regrant_mux", 32'(mux_en), 32'h05);

    // Long idle: counter saturates, release at the next latch
    dip = 2'b00; ir_data = 8'h00; key_data = 8'h22; btn_data = 8'h00;
    repeat (100) tick();
    check("sat_hold", 32'(dut.hold_cnt_q), 32'd4);
    check("sat_owner", 32'(owner), 32'h2);
    latch_cycle();
    check("release_owner", 32'(owner), 32'h1);
    check("release_pulse", 32'(switch_pulse), 32'h1);
    check("release_hold_clr", 32'(dut.hold_cnt_q), 32'd0);
    tick();
    check("release_mux", 32'(mux_en), 32'h22);

    // Active owner is kept even when a higher-priority source is active
    btn_data = 8'h80;
    latch_cycle();
    check("active_keep_owner", 32'(owner), 32'h1);
    check("active_keep_pulse", 32'(switch_pulse), 32'h0);

    // Everything idle: owner drops to NONE
    key_data = 8'h00; btn_data = 8'h00;
    repeat (6) tick();
    latch_cycle();
    check("drop_none_owner", 32'(owner), 32'h0);
    check("drop_none_pulse", 32'(switch_pulse), 32'h1);
    tick();
    check("drop_none_mux", 32'(mux_en), 32'h00);

    // All three rise together from NONE: buttons win
    key_data = 8'h01; ir_data = 8'h02; btn_data = 8'h03;
    latch_cycle();
    check("prio_owner", 32'(owner), 32'h3);
    tick();
    check("prio_mux", 32'(mux_en), 32'h03);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/snes_input_arbiter.md
# snes_input_arbiter

Frame-synchronous arbiter that shares the single SNES encoder input byte between the three controller decoders: keyboard, IR and button board. It sits between the three decoders and the SNES encoder. It replaces the purely combinational DIP-switch selection with an auto mode that grants the encoder to whichever source is in use. Ownership changes only at SNES latch boundaries, so the console never sees a frame mixed from two sources.

## Interface
Parameters:
- HOLD_CYCLES, 50000 — idle clocks the owner may sit at 8'h00 before it loses the grant (50 ms at 1 MHz); minimum 1.

Ports:
- clock  input  1  — system clock (1 MHz domain).
- reset  input  1  — synchronous, active-high; all state cleared on the clock edge where it is sampled high.
- key_data  input  8  — keyboard decoder byte; nonzero = active.
- ir_data  input  8  — IR decoder byte; nonzero = active.
- btn_data  input  8  — button board byte, already active-high; nonzero = active.
- dip  input  2  — mode: 00 auto, 01 force keyboard, 10 force IR, 11 force buttons.
- snes_latch  input  1  — console latch, asynchronous to clock.
- mux_en  output  8  — byte to SNES encoder; registered.
- owner  output  2  — current grant: 00 none, 01 keyboard, 10 IR, 11 buttons.
- switch_pulse  output  1  — high for exactly one cycle when owner changes.

## Operation
- Owner states: NONE, KEY, IR, BTN; encoded as on the owner port.
- Latch edge detect: synchronized snes_latch is compared against a delayed copy. A rising edge produces a one-cycle boundary strobe, which is the only point where owner may change.
- Decision at a boundary strobe:
  - Forced mode (dip ≠ 00): owner becomes the forced source, whether that source is active or not.
  - Auto mode, keep: owner ≠ NONE and (owner data ≠ 0 or hold_cnt < HOLD_CYCLES) → owner is kept.
  - Auto mode, regrant: otherwise owner goes to the highest-priority active source, BTN > KEY > IR. If no source is active, owner goes to NONE.
- hold_cnt:
  - Width $clog2(HOLD_CYCLES+1); saturates at HOLD_CYCLES, never wraps.
  - Cleared when owner data ≠ 0, when owner changes, and on reset.
  - Otherwise increments every cycle while owner ≠ NONE.
  - Held at 0 while owner = NONE.
- dip is sampled only at boundary strobes; a dip change between latches has no effect until the next latch.
- mux_en is loaded every cycle with the current owner's data byte, or 8'h00 when owner = NONE. Source data changes pass through within a frame; only ownership is frame-locked.
- switch_pulse is asserted on the cycle after owner is written with a different value.

## Timing
- Reset values: owner = 00, mux_en = 8'h00, switch_pulse = 0, hold_cnt = 0, synchronizer and edge flops = 0.
- If snes_latch is high when reset deasserts, that counts as a rising edge.
- Latch-to-owner latency: with the synchronizer, owner updates on the 3rd clock edge after the first edge that samples snes_latch high. Without the synchronizer (see Configuration), it updates on the 1st edge.
- The encoder samples its input at latch; the owner change lands after that sample, so the new owner takes effect from the following frame.
- mux_en lags owner and source data by 1 cycle.
- Latch pulses shorter than 1 clock may be missed; this is not required to be handled.
- Simultaneous boundary strobe and owner data going nonzero: the keep check uses the current-cycle data, so the owner is kept.
- Simultaneous activation of several sources from NONE: fixed priority applies, with no round-robin.
- Reset mid-frame: owner returns to NONE and is regranted at the next boundary.

## Configuration
- SNES_ARB_LATCH_SYNC_EN defined: snes_latch passes through a 2-flop synchronizer before edge detection (3-edge latency).
- SNES_ARB_LATCH_SYNC_EN undefined: snes_latch is treated as already synchronous to clock; only the edge-detect flop is present (1-edge latency). Use this only when the latch is generated in the clock domain.

## Test plan
(HOLD_CYCLES = 4, SNES_ARB_LATCH_SYNC_EN defined.)
- Reset held with all sources at 8'h00, then released; one latch pulse issued → owner 00, mux_en 8'h00, switch_pulse never asserted.
- dip = 00; key_data = 8'h10 and ir_data = 8'h01 raised together; one latch pulse → owner = 01 three edges after latch is sampled; switch_pulse one cycle; mux_en = 8'h10 one cycle later.
- Keyboard owner: key_data dropped to 0 and btn_data = 8'h80 raised; latch pulsed after 2 idle cycles → owner stays 01. Latch pulsed after 6 idle cycles → owner = 11 and mux_en = 8'h80.
- dip changed 00→10 mid-frame with ir_data = 0 → owner unchanged until the next latch, then owner = 10 and mux_en = 8'h00.
- IR owner with ir_data = 8'h05: reset asserted for one cycle between latches → owner 00 and mux_en 8'h00 the next cycle; owner = 10 is regranted at the following latch.
- Owner idle for 100 cycles → hold_cnt saturates at 4 with no wrap, and release occurs at the next latch.
